xbox_xlr_mem_resp: RTL and testbench

Memory responder on the XBOX accelerator-mastered memory interface. It holds NUM_MEMS line-organised SRAM instances and serves the accelerator's rd/wr/be/addr/wdata requests, returning registered read data one cycle later. It also provides a 32-bit host back-door port so SW or the bench can preload operands and read back results. This is the memory-side end of the xlr_mem_* bus used by xbox accelerators such as the 2x2 MatMul.

---
 rtl/xbox_mem_pkg.sv | 22 ++
 rtl/xbox_xlr_mem_resp_if.sv | 32 +++
 rtl/xbox_mem_line_bank.sv | 67 ++++++
 rtl/xbox_xlr_mem_resp.sv | 141 ++++++++++++++
 tb/tb_xbox_xlr_mem_resp.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xbox_mem_pkg.sv
// ---------------------------------------------------------------------------
// xbox_mem_pkg
// Shared types and constants for the XBOX accelerator memory responder.
//   XLR_LINE_WORDS / XLR_WORD_W : one memory line is 8 words of 32 bits
//   XLR_BE_W                    : one byte-enable bit per byte of a line
//   x_mem                       : symbolic memory instance selectors
//   line_t                      : packed line, word 0 in bits 31:0
// ---------------------------------------------------------------------------
package xbox_mem_pkg;

   localparam int unsigned XLR_LINE_WORDS = 8;
   localparam int unsigned XLR_WORD_W     = 32;
   localparam int unsigned XLR_BE_W       = 32;

   typedef enum logic [0:0] {
      MEM0 = 1'b0,
      MEM1 = 1'b1
   } x_mem;

   typedef logic [XLR_LINE_WORDS-1:0][XLR_WORD_W-1:0] line_t;

endpackage

// File: rtl/xbox_xlr_mem_resp_if.sv
// ---------------------------------------------------------------------------
// xbox_xlr_mem_resp_if
// Accelerator-mastered xlr_mem_* bus, one lane per memory instance.
//   master : accelerator side (drives addr/wdata/be/rd/wr)
//   slave  : memory responder side (returns rdata and collision pulses)
// ---------------------------------------------------------------------------
interface xbox_xlr_mem_resp_if
   import xbox_mem_pkg::*;
#(
   parameter int unsigned NUM_MEMS           = 2,
   parameter int unsigned LOG2_LINES_PER_MEM = 8
);

   logic  [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0] xlr_mem_addr;
   line_t [NUM_MEMS-1:0]                         xlr_mem_wdata;
   logic  [NUM_MEMS-1:0][XLR_BE_W-1:0]           xlr_mem_be;
   logic  [NUM_MEMS-1:0]                         xlr_mem_rd;
   logic  [NUM_MEMS-1:0]                         xlr_mem_wr;
   line_t [NUM_MEMS-1:0]                         xlr_mem_rdata;
   logic  [NUM_MEMS-1:0]                         xlr_collision;

   modport master (
      output xlr_mem_addr, xlr_mem_wdata, xlr_mem_be, xlr_mem_rd, xlr_mem_wr,
      input  xlr_mem_rdata, xlr_collision
   );

   modport slave (
      input  xlr_mem_addr, xlr_mem_wdata, xlr_mem_be, xlr_mem_rd, xlr_mem_wr,
      output xlr_mem_rdata, xlr_collision
   );

endinterface

// File: rtl/xbox_mem_line_bank.sv
// ---------------------------------------------------------------------------
// xbox_mem_line_bank
// One line-organised SRAM instance behind a single muxed access port.
//   clk, rst_n      : clock, asynchronous active-low reset (array not reset)
//   rd, wr          : access request; wr wins when both are set
//   host            : access belongs to the host back-door, not the xlr bus
//   addr, word      : line address, word index (host reads only)
//   wdata, be       : write line and per-byte enables
//   rdata           : xlr read line, held until the next xlr read
//   collision       : pulse after an xlr cycle with rd and wr both set
//   hrdata, hrvalid : host read word and its one-cycle valid pulse
// ---------------------------------------------------------------------------
module xbox_mem_line_bank
   import xbox_mem_pkg::*;
#(
   parameter int unsigned LOG2_LINES = 8
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rd,
   input  logic                  wr,
   input  logic                  host,
   input  logic [LOG2_LINES-1:0] addr,
   input  logic [2:0]            word,
   input  line_t                 wdata,
   input  logic [XLR_BE_W-1:0]   be,
   output line_t                 rdata,
   output logic                  collision,
   output logic [XLR_WORD_W-1:0] hrdata,
   output logic                  hrvalid
);

   line_t mem [0:(1 << LOG2_LINES)-1];

   logic rd_ok;
   assign rd_ok = rd & ~wr;

   // Byte-granular write; byte b sits in word b/4 at offset 8*(b%4).
   always_ff @(posedge clk) begin
      if (wr) begin
         for (int unsigned b = 0; b < XLR_BE_W; b++) begin
            if (be[b]) begin
               mem[addr][b/4][8*(b%4) +: 8] <= wdata[b/4][8*(b%4) +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata     <= '0;
         collision <= 1'b0;
         hrdata    <= '0;
         hrvalid   <= 1'b0;
      end else begin
         collision <= rd & wr & ~host;
         hrvalid   <= rd_ok & host;
         if (rd_ok && !host) begin
            rdata <= mem[addr];
         end
         if (rd_ok && host) begin
            hrdata <= mem[addr][word];
         end
      end
   end

endmodule

// File: rtl/xbox_xlr_mem_resp.sv
// ---------------------------------------------------------------------------
// xbox_xlr_mem_resp
// Memory responder for the xlr_mem_* bus with a 32-bit host back-door.
//   clk, rst_n      : clock, asynchronous active-low reset
//   xlr             : xlr_mem_* bus (slave side), one lane per instance
//   host_mem_sel    : host target instance (>= NUM_MEMS is ignored)
//   host_mem_addr   : host line address
//   host_mem_word   : word index within the line
//   host_mem_wdata  : host write word
//   host_mem_rd/wr  : host requests (wr wins when both are set)
//   host_mem_stall  : host request blocked by xlr traffic on its instance
//   host_mem_rdata  : last host read word (held between reads)
//   host_mem_rvalid : one-cycle pulse when host_mem_rdata is fresh
// ---------------------------------------------------------------------------
module xbox_xlr_mem_resp
   import xbox_mem_pkg::*;
#(
   parameter int unsigned NUM_MEMS           = 2,
   parameter int unsigned LOG2_LINES_PER_MEM = 8,
   localparam int unsigned SEL_W = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1
)(
   input  logic                          clk,
   input  logic                          rst_n,
   xbox_xlr_mem_resp_if.slave            xlr,
   input  logic [SEL_W-1:0]              host_mem_sel,
   input  logic [LOG2_LINES_PER_MEM-1:0] host_mem_addr,
   input  logic [2:0]                    host_mem_word,
   input  logic [XLR_WORD_W-1:0]         host_mem_wdata,
   input  logic                          host_mem_rd,
   input  logic                          host_mem_wr,
   output logic                          host_mem_stall,
   output logic [XLR_WORD_W-1:0]         host_mem_rdata,
   output logic                          host_mem_rvalid
);

   logic [NUM_MEMS-1:0]   xlr_busy;
   logic [NUM_MEMS-1:0]   host_hit;
   logic [NUM_MEMS-1:0]   host_go;
   logic                  host_req;
   line_t                 host_line;
   logic [XLR_BE_W-1:0]   host_be;
   logic [SEL_W-1:0]      last_sel;

   line_t                 rdata_all  [NUM_MEMS];
   logic                  coll_all   [NUM_MEMS];
   logic [XLR_WORD_W-1:0] hword_all  [NUM_MEMS];
   logic                  hvalid_all [NUM_MEMS];

   assign xlr_busy = xlr.xlr_mem_rd | xlr.xlr_mem_wr;
   assign host_req = host_mem_rd | host_mem_wr;

   // Decoded per instance so an out-of-range select simply hits nothing.
   always_comb begin
      host_hit = '0;
      for (int unsigned m = 0; m < NUM_MEMS; m++) begin
         host_hit[m] = (host_mem_sel == SEL_W'(m));
      end
   end

   assign host_go        = {NUM_MEMS{host_req}} & host_hit & ~xlr_busy;
   assign host_mem_stall = host_req & |(host_hit & xlr_busy);

   // Host writes are whole words: replicate the word, enable its 4 bytes.
   always_comb begin
      host_line = '0;
      for (int unsigned w = 0; w < XLR_LINE_WORDS; w++) begin
         host_line[w] = host_mem_wdata;
      end
      host_be = XLR_BE_W'(4'hF) << {host_mem_word, 2'b00};
   end

   for (genvar m = 0; m < NUM_MEMS; m++) begin : g_bank
      logic                          b_rd;
      logic                          b_wr;
      logic                          b_host;
      logic [LOG2_LINES_PER_MEM-1:0] b_addr;
      line_t                         b_wdata;
      logic [XLR_BE_W-1:0]           b_be;

      // xlr has strict priority on its instance; host only fills idle cycles.
      always_comb begin
         if (xlr_busy[m]) begin
            b_rd    = xlr.xlr_mem_rd[m];
            b_wr    = xlr.xlr_mem_wr[m];
            b_host  = 1'b0;
            b_addr  = xlr.xlr_mem_addr[m];
            b_wdata = xlr.xlr_mem_wdata[m];
            b_be    = xlr.xlr_mem_be[m];
         end else begin
            b_rd    = host_go[m] & host_mem_rd;
            b_wr    = host_go[m] & host_mem_wr;
            b_host  = 1'b1;
            b_addr  = host_mem_addr;
            b_wdata = host_line;
            b_be    = host_be;
         end
      end

      xbox_mem_line_bank #(
         .LOG2_LINES (LOG2_LINES_PER_MEM)
      ) u_bank (
         .clk       (clk),
         .rst_n     (rst_n),
         .rd        (b_rd),
         .wr        (b_wr),
         .host      (b_host),
         .addr      (b_addr),
         .word      (host_mem_word),
         .wdata     (b_wdata),
         .be        (b_be),
         .rdata     (rdata_all[m]),
         .collision (coll_all[m]),
         .hrdata    (hword_all[m]),
         .hrvalid   (hvalid_all[m])
      );
   end

   always_comb begin
      xlr.xlr_mem_rdata = '0;
      xlr.xlr_collision = '0;
      host_mem_rvalid   = 1'b0;
      for (int unsigned m = 0; m < NUM_MEMS; m++) begin
         xlr.xlr_mem_rdata[m] = rdata_all[m];
         xlr.xlr_collision[m] = coll_all[m];
         host_mem_rvalid      = host_mem_rvalid | hvalid_all[m];
      end
   end

   // Each bank holds its own last host word; remembering which bank served
   // the latest host read makes host_mem_rdata hold across idle cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_sel <= '0;
      end else if (host_mem_rd && !host_mem_wr && |host_go) begin
         last_sel <= host_mem_sel;
      end
   end

   assign host_mem_rdata = hword_all[last_sel];

endmodule

// File: tb/tb_xbox_xlr_mem_resp.sv
module tb_xbox_xlr_mem_resp;
   import xbox_mem_pkg::*;

   localparam int NM = 2;
   localparam int LG = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   xbox_xlr_mem_resp_if #(.NUM_MEMS(NM), .LOG2_LINES_PER_MEM(LG)) xif ();

   logic [0:0]  host_mem_sel;
   logic [7:0]  host_mem_addr;
   logic [2:0]  host_mem_word;
   logic [31:0] host_mem_wdata;
   logic        host_mem_rd;
   logic        host_mem_wr;
   logic        host_mem_stall;
   logic [31:0] host_mem_rdata;
   logic        host_mem_rvalid;

   xbox_xlr_mem_resp #(.NUM_MEMS(NM), .LOG2_LINES_PER_MEM(LG)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .xlr             (xif.slave),
      .host_mem_sel    (host_mem_sel),
      .host_mem_addr   (host_mem_addr),
      .host_mem_word   (host_mem_word),
      .host_mem_wdata  (host_mem_wdata),
      .host_mem_rd     (host_mem_rd),
      .host_mem_wr     (host_mem_wr),
      .host_mem_stall  (host_mem_stall),
      .host_mem_rdata  (host_mem_rdata),
      .host_mem_rvalid (host_mem_rvalid)
   );

   // Reference model: memory as flat 256-bit lines (byte b = bits 8b+7:8b),
   // only lines 0..15 are exercised.
   logic [255:0] mdl_mem [NM][16];
   logic [255:0] mdl_xrd [NM];
   logic [31:0]  mdl_hrd;

   typedef struct {
      logic [NM-1:0][255:0] xrd;
      logic [31:0]          hrd;
      logic                 hv;
      logic [NM-1:0]        coll;
   } exp_t;

   exp_t exp_q[$];

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   logic [255:0] snap_xrd [NM];
   logic [31:0]  snap_hrd;

   function automatic void check(string nm, logic [255:0] act, logic [255:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endfunction

   // Scoreboard monitor: one expected output set per cycle.
   always @(negedge clk) begin : mon
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("xlr_rdata0", xif.xlr_mem_rdata[0], e.xrd[0]);
         check("xlr_rdata1", xif.xlr_mem_rdata[1], e.xrd[1]);
         check("xlr_collision", 256'(xif.xlr_collision), 256'(e.coll));
         check("host_rvalid", 256'(host_mem_rvalid), 256'(e.hv));
         check("host_rdata", 256'(host_mem_rdata), 256'(e.hrd));
      end
   end

   task automatic begin_cyc();
      @(negedge clk);
      #1;
      for (int m = 0; m < NM; m++) snap_xrd[m] = xif.xlr_mem_rdata[m];
      snap_hrd           = host_mem_rdata;
      xif.xlr_mem_rd     = '0;
      xif.xlr_mem_wr     = '0;
      xif.xlr_mem_addr   = '0;
      xif.xlr_mem_wdata  = '0;
      xif.xlr_mem_be     = '0;
      host_mem_sel       = '0;
      host_mem_addr      = '0;
      host_mem_word      = '0;
      host_mem_wdata     = '0;
      host_mem_rd        = 1'b0;
      host_mem_wr        = 1'b0;
   endtask

   // Applies the spec rules to the inputs of this cycle and queues the
   // outputs expected after the next rising edge.
   task automatic end_cyc();
      exp_t e;
      int hs, ha, hw;
      logic hreq, busy, go, exp_stall;
      logic [255:0] wd;
      #1;
      e.coll = '0;
      e.hv   = 1'b0;
      hs   = int'(host_mem_sel);
      ha   = int'(host_mem_addr[3:0]);
      hw   = int'(host_mem_word);
      hreq = host_mem_rd | host_mem_wr;
      busy = (hs < NM) && (xif.xlr_mem_rd[hs] || xif.xlr_mem_wr[hs]);
      exp_stall = hreq && busy;
      go   = hreq && (hs < NM) && !busy;
      check("host_stall", 256'(host_mem_stall), 256'(exp_stall));
      if (!rst_n) begin
         for (int m = 0; m < NM; m++) mdl_xrd[m] = '0;
         mdl_hrd = '0;
      end else begin
         for (int m = 0; m < NM; m++) begin
            if (xif.xlr_mem_rd[m] && !xif.xlr_mem_wr[m])
               mdl_xrd[m] = mdl_mem[m][xif.xlr_mem_addr[m][3:0]];
            if (xif.xlr_mem_rd[m] && xif.xlr_mem_wr[m]) e.coll[m] = 1'b1;
         end
         if (go && host_mem_rd && !host_mem_wr) begin
            e.hv    = 1'b1;
            mdl_hrd = mdl_mem[hs][ha][32*hw +: 32];
         end
         for (int m = 0; m < NM; m++) begin
            if (xif.xlr_mem_wr[m]) begin
               wd = xif.xlr_mem_wdata[m];
               for (int b = 0; b < 32; b++)
                  if (xif.xlr_mem_be[m][b])
                     mdl_mem[m][xif.xlr_mem_addr[m][3:0]][8*b +: 8] = wd[8*b +: 8];
            end
         end
         if (go && host_mem_wr) mdl_mem[hs][ha][32*hw +: 32] = host_mem_wdata;
      end
      for (int m = 0; m < NM; m++) e.xrd[m] = mdl_xrd[m];
      e.hrd = mdl_hrd;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      begin_cyc();
      end_cyc();
   endtask

   task automatic hwrite(input x_mem s, input int a, input int w, input logic [31:0] d);
      begin_cyc();
      host_mem_sel = s; host_mem_addr = 8'(a); host_mem_word = 3'(w);
      host_mem_wdata = d; host_mem_wr = 1'b1;
      end_cyc();
   endtask

   task automatic hread_get(input x_mem s, input int a, input int w, output logic [31:0] d);
      begin_cyc();
      host_mem_sel = s; host_mem_addr = 8'(a); host_mem_word = 3'(w);
      host_mem_rd = 1'b1;
      end_cyc();
      idle();
      d = snap_hrd;
   endtask

   task automatic xread(input int m, input int a);
      begin_cyc();
      xif.xlr_mem_rd[m] = 1'b1; xif.xlr_mem_addr[m] = 8'(a);
      end_cyc();
   endtask

   task automatic xwrite(input int m, input int a, input line_t d, input logic [31:0] be);
      begin_cyc();
      xif.xlr_mem_wr[m] = 1'b1; xif.xlr_mem_addr[m] = 8'(a);
      xif.xlr_mem_wdata[m] = d; xif.xlr_mem_be[m] = be;
      end_cyc();
   endtask

   initial begin
      logic [255:0] exp1;
      logic [31:0]  d;
      logic [31:0]  a [4];
      logic [31:0]  b [4];
      line_t        ln;
      logic [31:0]  c_exp [4];

      exp1     = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
      c_exp[0] = 32'd19; c_exp[1] = 32'd22; c_exp[2] = 32'd43; c_exp[3] = 32'd50;
      for (int m = 0; m < NM; m++) mdl_xrd[m] = '0;
      mdl_hrd = '0;

      // Reset state
      begin_cyc(); rst_n = 1'b0; end_cyc();
      begin_cyc(); rst_n = 1'b0; end_cyc();
      begin_cyc(); rst_n = 1'b1; end_cyc();

      // Preload lines 0..15 of both instances through the host port
      for (int m = 0; m < NM; m++)
         for (int l = 0; l < 16; l++)
            for (int w = 0; w < 8; w++)
               hwrite(x_mem'(m), l, w, $urandom);

      // Host-built line read back over xlr, then held
      for (int w = 0; w < 8; w++) hwrite(MEM0, 0, w, 32'(w + 1));
      xread(0, 0);
      idle();
      check("xlr_line0_readback", snap_xrd[0], exp1);
      idle(); idle();
      check("xlr_line0_hold", snap_xrd[0], exp1);

      // Partial byte-enable write
      for (int w = 0; w < 8; w++) hwrite(MEM0, 1, w, 32'h0);
      xwrite(0, 1, {8{32'hFFFF_FFFF}}, 32'h0000_000F);
      hread_get(MEM0, 1, 0, d); check("be_word0", 256'(d), 256'(32'hFFFF_FFFF));
      hread_get(MEM0, 1, 1, d); check("be_word1", 256'(d), 256'(32'h0));
      xwrite(0, 2, {8{32'hDEAD_BEEF}}, 32'h0);
      xread(0, 2); idle();

      // Collision on MEM1 line 3
      xread(1, 5); idle();
      begin_cyc();
      xif.xlr_mem_rd[1] = 1'b1; xif.xlr_mem_wr[1] = 1'b1; xif.xlr_mem_addr[1] = 8'd3;
      xif.xlr_mem_wdata[1] = {8{32'h1234_5678}}; xif.xlr_mem_be[1] = 32'hFFFF_FFFF;
      end_cyc();
      idle();
      xread(1, 3); idle();

      // Host stalled behind xlr on MEM0; host on MEM1 proceeds meanwhile
      for (int k = 0; k < 2; k++) begin
         begin_cyc();
         xif.xlr_mem_rd[0] = 1'b1; xif.xlr_mem_addr[0] = 8'(4 + k);
         host_mem_sel = MEM0; host_mem_addr = 8'd2; host_mem_word = 3'd5; host_mem_rd = 1'b1;
         end_cyc();
      end
      begin_cyc();
      host_mem_sel = MEM0; host_mem_addr = 8'd2; host_mem_word = 3'd5; host_mem_rd = 1'b1;
      end_cyc();
      idle(); idle();
      begin_cyc();
      xif.xlr_mem_wr[0] = 1'b1; xif.xlr_mem_addr[0] = 8'd6;
      xif.xlr_mem_wdata[0] = {8{32'hA5A5_0000}}; xif.xlr_mem_be[0] = 32'h00FF_0F0F;
      host_mem_sel = MEM1; host_mem_addr = 8'd7; host_mem_word = 3'd2; host_mem_rd = 1'b1;
      end_cyc();
      idle();

      // Read-after-write on consecutive cycles
      xwrite(0, 1, {8{32'h0BAD_F00D}}, 32'hF0F0_F0F0);
      xread(0, 1);
      idle();

      // 2x2 MatMul driven over the xlr port
      for (int w = 0; w < 4; w++) hwrite(MEM0, 4, w, 32'(w + 1));
      for (int w = 0; w < 4; w++) hwrite(MEM1, 4, w, 32'(w + 5));
      begin_cyc();
      xif.xlr_mem_rd = 2'b11; xif.xlr_mem_addr[0] = 8'd4; xif.xlr_mem_addr[1] = 8'd4;
      end_cyc();
      idle();
      for (int w = 0; w < 4; w++) begin
         a[w] = snap_xrd[0][32*w +: 32];
         b[w] = snap_xrd[1][32*w +: 32];
      end
      ln = '0;
      ln[0] = a[0] * b[0] + a[1] * b[2];
      ln[1] = a[0] * b[1] + a[1] * b[3];
      ln[2] = a[2] * b[0] + a[3] * b[2];
      ln[3] = a[2] * b[1] + a[3] * b[3];
      xwrite(0, 1, ln, 32'h0000_FFFF);
      for (int w = 0; w < 4; w++) begin
         hread_get(MEM0, 1, w, d);
         check($sformatf("matmul_c%0d", w), 256'(d), 256'(c_exp[w]));
      end

      // Reset asserted while a host read is being presented
      begin_cyc();
      rst_n = 1'b0;
      host_mem_sel = MEM0; host_mem_addr = 8'd0; host_mem_word = 3'd3; host_mem_rd = 1'b1;
      end_cyc();
      begin_cyc(); rst_n = 1'b0; end_cyc();
      begin_cyc(); rst_n = 1'b1; end_cyc();
      idle();
      for (int w = 0; w < 8; w++) begin
         hread_get(MEM0, 0, w, d);
         check($sformatf("post_reset_word%0d", w), 256'(d), 256'(w + 1));
      end

      // Randomised traffic on both ports
      for (int k = 0; k < 400; k++) begin
         begin_cyc();
         for (int m = 0; m < NM; m++) begin
            xif.xlr_mem_rd[m]   = ($urandom_range(0, 2) == 0);
            xif.xlr_mem_wr[m]   = ($urandom_range(0, 3) == 0);
            xif.xlr_mem_addr[m] = 8'($urandom_range(0, 15));
            for (int w = 0; w < 8; w++) xif.xlr_mem_wdata[m][w] = $urandom;
            case ($urandom_range(0, 3))
               0:       xif.xlr_mem_be[m] = '0;
               1:       xif.xlr_mem_be[m] = '1;
               default: xif.xlr_mem_be[m] = $urandom;
            endcase
         end
         host_mem_sel   = 1'($urandom_range(0, 1));
         host_mem_addr  = 8'($urandom_range(0, 15));
         host_mem_word  = 3'($urandom_range(0, 7));
         host_mem_wdata = $urandom;
         host_mem_rd    = ($urandom_range(0, 1) == 0);
         host_mem_wr    = ($urandom_range(0, 3) == 0);
         end_cyc();
      end

      idle(); idle();
      @(negedge clk); #1;
      check("scoreboard_drained", 256'(exp_q.size()), 256'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
